// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone B3 master arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// searching cyclically.
module wb_rr_pick #(
    parameter int unsigned NR_REQ = 2,
    parameter int unsigned IDX_W  = 1
) (
    input  logic [NR_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NR_REQ-1:0] win_o,
    output logic [IDX_W-1:0]  win_idx_o,
    output logic              any_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NR_REQ; off++) begin
            cand = (32'(ptr_i) + off) % NR_REQ;
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                win_o[cand]     = 1'b1;
                win_idx_o       = IDX_W'(cand);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone B3 master arbiter: grant held for the whole cyc,
// per-transfer watchdog terminates unanswered strobes with err.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NR_REQ  = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [32*NR_REQ-1:0]  m_adr_i,
    input  logic [32*NR_REQ-1:0]  m_dat_i,
    input  logic [4*NR_REQ-1:0]   m_sel_i,
    input  logic [NR_REQ-1:0]     m_cyc_i,
    input  logic [NR_REQ-1:0]     m_stb_i,
    input  logic [NR_REQ-1:0]     m_we_i,
    input  logic [3*NR_REQ-1:0]   m_cti_i,
    input  logic [2*NR_REQ-1:0]   m_bte_i,
    output logic [31:0]           m_dat_o,
    output logic [NR_REQ-1:0]     m_ack_o,
    output logic [NR_REQ-1:0]     m_err_o,
    output logic [NR_REQ-1:0]     m_rty_o,
    output logic [31:0]           s_adr_o,
    output logic [31:0]           s_dat_o,
    output logic [3:0]            s_sel_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [NR_REQ-1:0]     grant_o,
    output logic                  timeout_o
);

    localparam int unsigned      IDX_W    = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_REQ - 1);
    localparam logic [TO_W-1:0]  WD_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic             WD_EN    = (TIMEOUT != 0);

    arb_state_e        state_q, state_d;
    logic [NR_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  gidx_q,  gidx_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [TO_W-1:0]   wd_q,    wd_d;

    logic [NR_REQ-1:0] pick_win;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic gnt_cyc;
    logic gnt_stb;
    logic term;
    logic wd_fire;

    wb_rr_pick #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req_i     (m_cyc_i),
        .ptr_i     (ptr_q),
        .win_o     (pick_win),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // Grant is zero in IDLE, so muxing on it alone yields all-zero outputs there.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = CTI_CLASSIC;
        s_bte_o = '0;
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            if (grant_q[k]) begin
                s_adr_o = m_adr_i[32*k +: 32];
                s_dat_o = m_dat_i[32*k +: 32];
                s_sel_o = m_sel_i[4*k +: 4];
                s_we_o  = m_we_i[k];
                s_cti_o = m_cti_i[3*k +: 3];
                s_bte_o = m_bte_i[2*k +: 2];
                gnt_cyc = m_cyc_i[k];
                gnt_stb = m_stb_i[k];
            end
        end
    end

    assign term    = s_ack_i | s_err_i | s_rty_i;
    // A slave termination in the firing cycle takes precedence over the watchdog.
    assign wd_fire = WD_EN && (state_q == BUSY) && gnt_stb && !term && (wd_q == WD_LAST);

    assign s_cyc_o   = gnt_cyc;
    assign s_stb_o   = gnt_stb & ~wd_fire;
    assign m_dat_o   = (|grant_q) ? s_dat_i : '0;
    assign m_ack_o   = grant_q & {NR_REQ{s_ack_i}};
    assign m_err_o   = grant_q & {NR_REQ{s_err_i | wd_fire}};
    assign m_rty_o   = grant_q & {NR_REQ{s_rty_i}};
    assign grant_o   = grant_q;
    assign timeout_o = wd_fire;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        wd_d    = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    grant_d = pick_win;
                    gidx_d  = pick_idx;
                end
            end
            BUSY: begin
                if (!gnt_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
                end else if (WD_EN && gnt_stb && !term && !wd_fire) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: vector table plus burst and
// asynchronous-reset sequences.
module tb_wb_master_arbiter;

    localparam int unsigned N = 2;
    localparam logic [31:0] A0 = 32'h2000_0010;
    localparam logic [31:0] A1 = 32'h3000_0020;
    localparam logic [31:0] RD = 32'hCAFE_F00D;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [32*N-1:0]   m_adr, m_dat;
    logic [4*N-1:0]    m_sel;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [3*N-1:0]    m_cti;
    logic [2*N-1:0]    m_bte;
    logic [31:0]       m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
    logic [31:0]       s_adr_o, s_dat_o;
    logic [3:0]        s_sel_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic [31:0]       s_dat_i;
    logic              s_ack, s_err, s_rty;
    logic [N-1:0]      grant_o;
    logic              timeout_o;

    int checks = 0;
    int errors = 0;

    wb_master_arbiter #(
        .NR_REQ  (N),
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_sel_i   (m_sel),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_cti_i   (m_cti),
        .m_bte_i   (m_bte),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_rty_o   (m_rty_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_cti_o   (s_cti_o),
        .s_bte_o   (s_bte_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_rty_i   (s_rty),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic       err;
        logic [1:0] e_grant;
        logic       e_scyc;
        logic       e_sstb;
        logic [1:0] e_ack;
        logic [1:0] e_err;
        logic       e_to;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_adr(input logic [1:0] g);
        return (g == 2'b01) ? A0 : (g == 2'b10) ? A1 : 32'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        //          rst  cyc    stb    ack   err   grant  scyc  sstb  ack    err    to
        vecs[0]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[12] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[13] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[14] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[15] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[16] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[17] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[18] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1};
        vecs[19] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[20] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0};
        vecs[21] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[22] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[23] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[24] = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0};
        vecs[25] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[26] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

        m_adr   = {A1, A0};
        m_dat   = {32'h1111_1111, 32'h0000_0000};
        m_sel   = 8'hF3;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = 2'b10;
        m_cti   = {3'b000, 3'b000};
        m_bte   = '0;
        s_dat_i = RD;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rty   = 1'b0;

        rst = 1'b1;
        #1;
        check("reset_grant",  32'(grant_o),   32'h0);
        check("reset_s_cyc",  32'(s_cyc_o),   32'h0);
        check("reset_s_adr",  s_adr_o,        32'h0);
        check("reset_m_dat",  m_dat_o,        32'h0);
        check("reset_timeout", 32'(timeout_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            tick();
            rst   = vecs[i].rst;
            m_cyc = vecs[i].cyc;
            m_stb = vecs[i].stb;
            s_ack = vecs[i].ack;
            s_err = vecs[i].err;
            #1;
            check($sformatf("v%0d_grant", i),   32'(grant_o),   32'(vecs[i].e_grant));
            check($sformatf("v%0d_s_cyc", i),   32'(s_cyc_o),   32'(vecs[i].e_scyc));
            check($sformatf("v%0d_s_stb", i),   32'(s_stb_o),   32'(vecs[i].e_sstb));
            check($sformatf("v%0d_m_ack", i),   32'(m_ack_o),   32'(vecs[i].e_ack));
            check($sformatf("v%0d_m_err", i),   32'(m_err_o),   32'(vecs[i].e_err));
            check($sformatf("v%0d_timeout", i), 32'(timeout_o), 32'(vecs[i].e_to));
            check($sformatf("v%0d_s_adr", i),   s_adr_o,        exp_adr(vecs[i].e_grant));
            check($sformatf("v%0d_m_dat", i),   m_dat_o,        (vecs[i].e_grant != 2'b00) ? RD : 32'h0);
        end

        // 4-beat burst by master 0 while master 1 keeps requesting
        tick();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_cti = {3'b000, 3'b010};
        s_ack = 1'b0;
        s_err = 1'b0;
        #1;
        check("burst_idle_grant", 32'(grant_o), 32'h0);
        for (int b = 0; b < 4; b++) begin
            tick();
            m_cyc = 2'b11;
            m_stb = 2'b11;
            m_cti = {3'b000, (b == 3) ? 3'b111 : 3'b010};
            s_ack = 1'b1;
            #1;
            check($sformatf("burst%0d_grant", b), 32'(grant_o), 32'h1);
            check($sformatf("burst%0d_cti", b),   32'(s_cti_o), (b == 3) ? 32'h7 : 32'h2);
            check($sformatf("burst%0d_ack", b),   32'(m_ack_o), 32'h1);
            check($sformatf("burst%0d_sel", b),   32'(s_sel_o), 32'h3);
        end
        tick();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        m_cti = '0;
        s_ack = 1'b0;
        #1;
        check("burst_release_cyc",   32'(s_cyc_o), 32'h0);
        check("burst_release_grant", 32'(grant_o), 32'h1);
        tick();
        #1;
        check("burst_gap_grant", 32'(grant_o), 32'h0);

        // Master 0 alone again with pointer at 1, then async reset mid-beat
        tick();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        #1;
        check("ar_idle_grant", 32'(grant_o), 32'h0);
        tick();
        #1;
        check("ar_busy_grant", 32'(grant_o), 32'h1);
        check("ar_busy_cyc",   32'(s_cyc_o), 32'h1);
        #3;
        s_ack = 1'b1;
        rst   = 1'b1;
        #1;
        check("ar_grant",   32'(grant_o), 32'h0);
        check("ar_s_cyc",   32'(s_cyc_o), 32'h0);
        check("ar_m_ack",   32'(m_ack_o), 32'h0);
        check("ar_s_adr",   s_adr_o,      32'h0);
        tick();
        rst   = 1'b0;
        s_ack = 1'b0;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        #1;
        check("post_rst_idle", 32'(grant_o), 32'h0);
        tick();
        #1;
        check("post_rst_grant_ptr0", 32'(grant_o), 32'h1);
        tick();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Round-robin arbiter sharing the single master port of wb_bus_b3 between several Wishbone B3 bus masters (e.g. picorv32 plus a future DMA/debug master).
- Grant is held for a whole cycle (cyc) so multi-beat and read-modify-write sequences stay atomic.
- A per-transfer watchdog terminates hung accesses with err, so a missing slave cannot lock the SoC.

Parameters:
- NR_REQ, 2, number of requesting masters (1..8).
- TIMEOUT, 255, cycles an unacknowledged strobe may wait before watchdog err; 0 disables the watchdog.
- TO_W, 8, width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- m_adr_i  in  32*NR_REQ  flat master addresses; master k at [32k+31:32k]
- m_dat_i  in  32*NR_REQ  flat master write data
- m_sel_i  in  4*NR_REQ  flat byte selects
- m_cyc_i  in  NR_REQ  cycle valid per master
- m_stb_i  in  NR_REQ  strobe per master
- m_we_i  in  NR_REQ  write enable per master
- m_cti_i  in  3*NR_REQ  cycle type per master
- m_bte_i  in  2*NR_REQ  burst type per master
- m_dat_o  out  32  read data, broadcast to all masters
- m_ack_o  out  NR_REQ  ack, granted master only
- m_err_o  out  NR_REQ  err, granted master only (bus err OR watchdog)
- m_rty_o  out  NR_REQ  rty, granted master only
- s_adr_o  out  32  shared address toward bus
- s_dat_o  out  32  write data
- s_sel_o  out  4  byte selects
- s_cyc_o  out  1  cycle
- s_stb_o  out  1  strobe
- s_we_o  out  1  write enable
- s_cti_o  out  3  cycle type
- s_bte_o  out  2  burst type
- s_dat_i  in  32  read data from bus
- s_ack_i  in  1  ack from bus
- s_err_i  in  1  err from bus
- s_rty_i  in  1  rty from bus
- grant_o  out  NR_REQ  one-hot current grant, for debug/snoop
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async): state IDLE, grant_o=0, rr pointer=0, watchdog counter=0. s_cyc_o, s_stb_o, s_we_o, all m_ack/err/rty_o and timeout_o are 0. s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o and m_dat_o are 0 while grant_o=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any m_cyc_i is set, pick the first requester at or after the rr pointer (cyclic search).
  - Register its one-hot grant; go to BUSY. Grant latency is 1 cycle from cyc.
  - No requester: stay in IDLE.
- BUSY:
  - s_* = granted master's signals (combinational mux on the registered grant).
  - s_dat_i is forwarded to m_dat_o.
  - s_ack_i, s_err_i and s_rty_i are routed to the granted bit only; all other masters see 0.
- Release:
  - Triggered when the granted m_cyc_i=0 in BUSY.
  - Next cycle: state IDLE, grant_o=0, rr pointer = granted index+1 (mod NR_REQ).
  - s_cyc_o drops combinationally in the release cycle.
  - There is always one idle cycle between grants, so back-to-back ownership changes cost 2 cycles.
- Non-granted masters: their cyc/stb are ignored, with no ack and no error, until granted.
- Watchdog:
  - Counter increments each BUSY cycle with s_stb_o=1 and no ack/err/rty.
  - It clears on any termination, on stb=0, or in IDLE.
  - When counter==TIMEOUT-1 and still unterminated: m_err_o[granted]=1 and timeout_o=1 for that cycle, s_stb_o is forced to 0 in that cycle, and the counter clears.
  - A slave ack arriving in the same cycle wins: the ack is passed, no err, no timeout.
  - The grant is kept; the master decides whether to drop cyc.
- Single requester: it regains the bus after a 1-cycle IDLE gap; no starvation.
- Simultaneous requests: the rr pointer decides; the master just served has lowest priority next.
- Reset mid-transfer: everything returns to the reset values immediately. No ack/err is issued for the aborted beat.
- NR_REQ=1: degenerates to a registered pass-through with the same 1-cycle grant latency and the same watchdog.

Decomposition:
- Shared package wb_arb_pkg: fsm state typedef (IDLE, BUSY) and a WB B3 cti localparam (CTI_CLASSIC=3'b000, CTI_EOB=3'b111).
- One sub-module, wb_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer. Outputs: one-hot winner, winner index.
  - Reusable for future slave-side arbitration.

Test Plan:
1. Reset, then m_cyc_i=2'b01 with stb, adr=32'h2000_0010 -> cycle+1: grant_o=01, s_adr_o=32'h2000_0010; slave ack -> m_ack_o=01, m_ack_o[1]=0.
2. Both masters assert cyc in the same cycle, pointer 0 -> master 0 granted. After master 0 drops cyc: 1 idle cycle, then grant_o=10, then master 0 again after master 1 drops.
3. Master 0 does a 4-beat burst (cti 010, then 111) while master 1 requests -> grant stays 01 for all 4 acks; s_cti_o follows master 0; master 1 sees no ack.
4. TIMEOUT=4, granted stb with no slave response -> at the 4th waiting cycle m_err_o=01 and timeout_o=1 for 1 cycle, s_stb_o=0 that cycle; grant held.
5. TIMEOUT=4, slave ack on exactly the 4th waiting cycle -> m_ack_o=01, m_err_o=0, timeout_o=0.
6. Assert wb_rst_i asynchronously mid-BUSY -> s_cyc_o, grant_o and m_ack_o go to 0 the same cycle; after release the first request is arbitrated from pointer 0.
